mem_bus_arbiter: RTL and testbench

// - Shares one dbus-style memory port between the fetch stage (ibus) and the memory stage (dbus).
// - Sits between the CPU pipeline and the single-channel bus bridge.
// - Grants one requester at a time and forwards that requester's request.
// - Routes the addr_ok/data_ok/data response back to the granted side only.
// - Allows at most one outstanding transaction.

---
 rtl/mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-port memory bus arbiter: fetch (ibus) and memory stage (dbus) share one dbus-style port.
// Latency: one cycle from request to downstream valid; responses are forwarded combinationally to the granted side.
// Backpressure: stalls through addr_ok/data_ok; one outstanding transaction; optional MEM_ARB_ROUND_ROBIN_EN tie-break.

package mem_bus_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  mreq,
    input  dbus_resp_t mresp,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IADDR = 3'd1,
        IDATA = 3'd2,
        DADDR = 3'd3,
        DDATA = 3'd4
    } state_t;

    state_t      state_q, state_d;
    dbus_req_t   hold_q, hold_d;     // granted request, replayed with valid low during the data phase
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
    dbus_req_t   ifetch_req;
    logic        pick_dbus;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dbus_q, last_dbus_d;  // 1 = dbus was granted most recently

    // Tie goes to whichever side was not granted last; a lone request always wins
    always_comb begin
        pick_dbus = dreq.valid & ~(ireq.valid & last_dbus_q);
    end

    // Remember the winner whenever an address phase is started from IDLE
    always_comb begin
        last_dbus_d = last_dbus_q;
        if (state_q == IDLE && (dreq.valid || ireq.valid)) begin
            last_dbus_d = pick_dbus;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dbus_q <= 1'b0;
        end else begin
            last_dbus_q <= last_dbus_d;
        end
    end
`else
    // Fixed priority: the memory stage always wins a tie
    always_comb begin
        pick_dbus = dreq.valid;
    end
`endif

    // Fetches are always full-word reads
    always_comb begin
        ifetch_req       = '0;
        ifetch_req.valid = ireq.valid;
        ifetch_req.addr  = ireq.addr;
        ifetch_req.size  = MSIZE4;
    end

    // Next-state, request muxing, response routing and watchdog
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        mreq      = '0;
        iresp     = '0;
        dresp     = '0;

        case (state_q)
            IDLE: begin
                if (pick_dbus) begin
                    state_d = DADDR;
                end else if (ireq.valid) begin
                    state_d = IADDR;
                end
            end

            IADDR: begin
                mreq          = ifetch_req;
                hold_d        = ifetch_req;
                iresp.addr_ok = mresp.addr_ok;
                // data_ok without addr_ok is not a legal completion here
                iresp.data_ok = mresp.addr_ok & mresp.data_ok;
                iresp.data    = mresp.data;
                if (!ireq.valid) begin
                    state_d = IDLE;
                end else if (mresp.addr_ok && mresp.data_ok) begin
                    state_d = IDLE;
                end else if (mresp.addr_ok) begin
                    state_d = IDATA;
                end
            end

            IDATA: begin
                mreq          = hold_q;
                mreq.valid    = 1'b0;
                iresp.data_ok = mresp.data_ok;
                iresp.data    = mresp.data;
                if (mresp.data_ok) begin
                    state_d = IDLE;
                end
            end

            DADDR: begin
                mreq          = dreq;
                hold_d        = dreq;
                dresp.addr_ok = mresp.addr_ok;
                dresp.data_ok = mresp.addr_ok & mresp.data_ok;
                dresp.data    = mresp.data;
                if (!dreq.valid) begin
                    state_d = IDLE;
                end else if (mresp.addr_ok && mresp.data_ok) begin
                    state_d = IDLE;
                end else if (mresp.addr_ok) begin
                    state_d = DDATA;
                end
            end

            DDATA: begin
                mreq          = hold_q;
                mreq.valid    = 1'b0;
                dresp.data_ok = mresp.data_ok;
                dresp.data    = mresp.data;
                if (mresp.data_ok) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter is zero whenever an address phase begins and saturates instead of wrapping
        if (state_q == IDLE) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d = wdog_q + 32'd1;
        end

        if (TIMEOUT_CYCLES != 0 && state_q != IDLE && wdog_d == TIMEOUT_CYCLES) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    // State, held request, watchdog and sticky timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned TO = 8;
    localparam logic [31:0] IA  = 32'h1000_0040;
    localparam logic [31:0] DA  = 32'h8000_0100;
    localparam logic [31:0] DA2 = 32'h8000_0200;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  mreq;
    dbus_resp_t mresp;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq),
        .iresp  (iresp),
        .dreq   (dreq),
        .dresp  (dresp),
        .mreq   (mreq),
        .mresp  (mresp),
        .busy   (busy),
        .timeout(timeout)
    );

    task automatic test_reset();
        reset = 1'b1; ireq = '0; dreq = '0; mresp = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%0b exp=0", timeout); end
        checks++; if (mreq.valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%0b exp=0", mreq.valid); end
        checks++; if (iresp !== ibus_resp_t'(0) || dresp !== dbus_resp_t'(0)) begin errors++; $display("FAIL rst_resp iresp=%h dresp=%h exp=0", iresp, dresp); end
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch();
        ibus_resp_t ei;
        @(negedge clk); ireq = '{valid: 1'b1, addr: 32'hBFC0_0000}; #1;
        checks++; if (mreq.valid !== 1'b0) begin errors++; $display("FAIL fetch_latency mvalid=%0b exp=0", mreq.valid); end
        @(negedge clk); #1;
        checks++; if (mreq.valid !== 1'b1 || mreq.addr !== 32'hBFC0_0000 || mreq.size !== MSIZE4 || mreq.strobe !== 4'h0)
            begin errors++; $display("FAIL fetch_req got=%h exp valid=1 addr=bfc00000 size=MSIZE4 strobe=0", mreq); end
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0}; #1;
        ei = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        checks++; if (iresp !== ei) begin errors++; $display("FAIL fetch_addr_ok got=%h exp=%h", iresp, ei); end
        @(negedge clk); mresp = '0; #1;
        checks++; if (mreq.valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_data_wait mvalid=%0b busy=%0b exp 0,1", mreq.valid, busy); end
        @(negedge clk); mresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h2402_0001}; #1;
        ei = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h2402_0001};
        checks++; if (iresp !== ei) begin errors++; $display("FAIL fetch_data got=%h exp=%h", iresp, ei); end
        checks++; if (dresp !== dbus_resp_t'(0)) begin errors++; $display("FAIL fetch_dresp_quiet got=%h exp=0", dresp); end
        @(negedge clk); mresp = '0; ireq.valid = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_done_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_tie();
        dbus_resp_t ed;
        ibus_resp_t ei;
        @(negedge clk);
        ireq = '{valid: 1'b1, addr: IA};
        dreq = '{valid: 1'b1, addr: DA, size: MSIZE4, strobe: 4'hF, data: 32'hCAFE_F00D};
        #1;
        checks++; if (mreq.valid !== 1'b0) begin errors++; $display("FAIL tie_latency mvalid=%0b exp=0", mreq.valid); end
        @(negedge clk); #1;
        checks++; if (mreq !== dreq) begin errors++; $display("FAIL tie_dgrant got=%h exp=%h", mreq, dreq); end
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0}; #1;
        ed = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        checks++; if (dresp !== ed || iresp !== ibus_resp_t'(0)) begin errors++; $display("FAIL tie_dcomplete dresp=%h iresp=%h exp %h,0", dresp, iresp, ed); end
        @(negedge clk); dreq.valid = 1'b0; mresp = '0; #1;
        checks++; if (busy !== 1'b0 || mreq.valid !== 1'b0) begin errors++; $display("FAIL tie_idle_gap busy=%0b mvalid=%0b exp 0,0", busy, mreq.valid); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1 || mreq.valid !== 1'b1 || mreq.addr !== IA) begin errors++; $display("FAIL tie_igrant busy=%0b mreq=%h exp addr=%h", busy, mreq, IA); end
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1111_2222}; #1;
        ei = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1111_2222};
        checks++; if (iresp !== ei) begin errors++; $display("FAIL tie_icomplete got=%h exp=%h", iresp, ei); end
        @(negedge clk); ireq.valid = 1'b0; mresp = '0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_end_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_tie_after_d();
        logic [31:0] first, second;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first = IA; second = DA;
`else
        first = DA; second = IA;
`endif
        @(negedge clk); dreq = '{valid: 1'b1, addr: DA2, size: MSIZE1, strobe: 4'h0, data: 32'h0};
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h5555_AAAA}; #1;
        checks++; if (dresp.data_ok !== 1'b1 || dresp.data !== 32'h5555_AAAA) begin errors++; $display("FAIL lone_d_complete got=%h", dresp); end
        @(negedge clk); dreq.valid = 1'b0; mresp = '0;
        @(negedge clk);
        ireq = '{valid: 1'b1, addr: IA};
        dreq = '{valid: 1'b1, addr: DA, size: MSIZE2, strobe: 4'h3, data: 32'h0000_BEEF};
        @(negedge clk); #1;
        checks++; if (mreq.valid !== 1'b1 || mreq.addr !== first) begin errors++; $display("FAIL tie2_first mreq=%h exp addr=%h", mreq, first); end
        mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        @(negedge clk);
        if (first == IA) ireq.valid = 1'b0; else dreq.valid = 1'b0;
        mresp = '0;
        @(negedge clk); #1;
        checks++; if (mreq.valid !== 1'b1 || mreq.addr !== second) begin errors++; $display("FAIL tie2_second mreq=%h exp addr=%h", mreq, second); end
        mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
        @(negedge clk); ireq.valid = 1'b0; dreq.valid = 1'b0; mresp = '0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie2_end_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_abort();
        @(negedge clk); dreq = '{valid: 1'b1, addr: DA, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        @(negedge clk); #1;
        checks++; if (mreq.valid !== 1'b1) begin errors++; $display("FAIL abort_grant mvalid=%0b exp=1", mreq.valid); end
        dreq.valid = 1'b0; #1;
        checks++; if (mreq.valid !== 1'b0 || dresp !== dbus_resp_t'(0)) begin errors++; $display("FAIL abort_drop mvalid=%0b dresp=%h exp 0,0", mreq.valid, dresp); end
        @(negedge clk); mresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hDEAD_BEEF}; #1;
        checks++; if (busy !== 1'b0 || mreq.valid !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%0b mvalid=%0b exp 0,0", busy, mreq.valid); end
        checks++; if (dresp !== dbus_resp_t'(0) || iresp !== ibus_resp_t'(0)) begin errors++; $display("FAIL idle_stray_dataok dresp=%h iresp=%h exp 0,0", dresp, iresp); end
        @(negedge clk); mresp = '0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_stray_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); ireq = '{valid: 1'b1, addr: IA};
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        @(negedge clk); mresp = '0; #1;
        checks++; if (busy !== 1'b1 || mreq.valid !== 1'b0) begin errors++; $display("FAIL rmid_idata busy=%0b mvalid=%0b exp 1,0", busy, mreq.valid); end
        mresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h7777_0000}; reset = 1'b1; #1;
        checks++; if (busy !== 1'b0 || iresp !== ibus_resp_t'(0)) begin errors++; $display("FAIL rmid_async busy=%0b iresp=%h exp 0,0", busy, iresp); end
        @(negedge clk); reset = 1'b0; ireq = '0; mresp = '0; #1;
        checks++; if (busy !== 1'b0 || iresp !== ibus_resp_t'(0)) begin errors++; $display("FAIL rmid_after busy=%0b iresp=%h exp 0,0", busy, iresp); end
    endtask

    // Transaction-level model: which side owns the bus, plus the bench's own bridge timing.
    task automatic test_random();
        int owner = 0;            // 0 none, 1 fetch, 2 memory stage
        bit acc = 1'b0;
        int adly = 0, ddly = 0;
        bit last_d = 1'b0;
        bit i_done = 1'b0, d_done = 1'b0;
        int i_cnt = 0, d_cnt = 0;
        bit a_ok, d_ok, stray;
        int winner;
        ibus_resp_t ei;
        dbus_resp_t ed;
        dbus_req_t  em;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (i_done || !ireq.valid) begin
                if ($urandom_range(0, 2) == 0) ireq = '{valid: 1'b1, addr: $urandom & 32'hFFFF_FFFC};
                else ireq.valid = 1'b0;
            end
            if (d_done || !dreq.valid) begin
                if ($urandom_range(0, 2) == 0)
                    dreq = '{valid: 1'b1, addr: $urandom, size: msize_t'($urandom_range(0, 2)),
                             strobe: 4'($urandom), data: $urandom};
                else dreq.valid = 1'b0;
            end
            i_done = 1'b0; d_done = 1'b0;
            a_ok = 1'b0; d_ok = 1'b0; stray = 1'b0;
            if (owner != 0) begin
                if (!acc) begin
                    if (adly == 0) begin a_ok = 1'b1; d_ok = (ddly == 0); end
                    else stray = ($urandom_range(0, 3) == 0);
                end else d_ok = (ddly == 0);
            end else stray = ($urandom_range(0, 4) == 0);
            mresp = '{addr_ok: a_ok, data_ok: d_ok | stray, data: $urandom};
            #1;
            ei = '0; ed = '0;
            if (owner == 1) ei = '{addr_ok: a_ok, data_ok: d_ok, data: mresp.data};
            if (owner == 2) ed = '{addr_ok: a_ok, data_ok: d_ok, data: mresp.data};
            checks++; if (busy !== (owner != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, owner != 0); end
            checks++; if (mreq.valid !== (owner != 0 && !acc)) begin errors++; $display("FAIL rnd_mvalid cyc=%0d got=%0b exp=%0b", cyc, mreq.valid, owner != 0 && !acc); end
            if (owner != 0 && !acc) begin
                em = (owner == 1) ? '{valid: 1'b1, addr: ireq.addr, size: MSIZE4, strobe: 4'h0, data: 32'h0} : dreq;
                checks++; if (mreq !== em) begin errors++; $display("FAIL rnd_mreq cyc=%0d got=%h exp=%h", cyc, mreq, em); end
            end
            checks++; if (iresp !== ei) begin errors++; $display("FAIL rnd_iresp cyc=%0d got=%h exp=%h", cyc, iresp, ei); end
            checks++; if (dresp !== ed) begin errors++; $display("FAIL rnd_dresp cyc=%0d got=%h exp=%h", cyc, dresp, ed); end
            if (owner != 0) begin
                if (d_ok) begin
                    if (owner == 1) begin i_done = 1'b1; i_cnt++; end
                    else begin d_done = 1'b1; d_cnt++; end
                    owner = 0;
                end else if (a_ok) begin acc = 1'b1; ddly--; end
                else if (!acc) adly--;
                else ddly--;
            end else begin
                winner = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (dreq.valid && ireq.valid) winner = last_d ? 1 : 2;
`else
                if (dreq.valid && ireq.valid) winner = 2;
`endif
                else if (dreq.valid) winner = 2;
                else if (ireq.valid) winner = 1;
                if (winner != 0) begin
                    owner = winner; acc = 1'b0; last_d = (winner == 2);
                    adly = $urandom_range(0, 2); ddly = $urandom_range(0, 2);
                end
            end
        end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rnd_no_timeout got=%0b exp=0", timeout); end
        checks++; if (i_cnt == 0 || d_cnt == 0) begin errors++; $display("FAIL rnd_progress fetch=%0d mem=%0d exp both >0", i_cnt, d_cnt); end
    endtask

    task automatic test_timeout();
        @(negedge clk); reset = 1'b1; ireq = '0; dreq = '0; mresp = '0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); ireq = '{valid: 1'b1, addr: 32'hBFC0_0100}; #1;
        checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_start busy=%0b timeout=%0b exp 0,0", busy, timeout); end
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk); #1;
            checks++; if ({busy, timeout} !== 2'b10) begin errors++; $display("FAIL to_wait k=%0d busy=%0b timeout=%0b exp 1,0", k, busy, timeout); end
        end
        @(negedge clk); ireq.valid = 1'b0; #1;
        checks++; if (busy !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL to_fire busy=%0b timeout=%0b exp 0,1", busy, timeout); end
        @(negedge clk); dreq = '{valid: 1'b1, addr: DA, size: MSIZE4, strobe: 4'h0, data: 32'h0};
        @(negedge clk); mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0}; #1;
        checks++; if (dresp.data_ok !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL to_sticky dresp=%h timeout=%0b exp data_ok=1 timeout=1", dresp, timeout); end
        @(negedge clk); dreq.valid = 1'b0; mresp = '0; reset = 1'b1; #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear got=%0b exp=0", timeout); end
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_tie();
        test_tie_after_d();
        test_abort();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
